// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter frame scheduler: FSM encoding,
// pixel colours, meter zone thresholds and the bar colour lookup.
package vu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DECAY  = 2'd2
  } state_e;

  localparam logic [11:0] COLOR_BLACK  = 12'h000;
  localparam logic [11:0] COLOR_GREY   = 12'h222;
  localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
  localparam logic [11:0] COLOR_YELLOW = 12'hFF0;
  localparam logic [11:0] COLOR_RED    = 12'hF00;
  localparam logic [11:0] COLOR_WHITE  = 12'hFFF;

  localparam int ZONE_GREEN_END  = 160;
  localparam int ZONE_YELLOW_END = 224;

  // Colour of pixel index p inside one channel's bar; the peak marker wins.
  function automatic logic [11:0] bar_colour(input logic [15:0] p,
                                             input logic [7:0]  level,
                                             input logic [7:0]  peak);
    logic [11:0] c;
    c = COLOR_GREY;
    if (peak != 8'd0 && p == {8'd0, peak}) begin
      c = COLOR_WHITE;
    end else if (p < {8'd0, level}) begin
      if (p < 16'(ZONE_GREEN_END))       c = COLOR_GREEN;
      else if (p < 16'(ZONE_YELLOW_END)) c = COLOR_YELLOW;
      else                               c = COLOR_RED;
    end
    return c;
  endfunction

endpackage

// File: rtl/vu_peak_hold.sv
// Per-channel peak tracker: captures new highs, holds them for a number of
// frames, then lets the marker fall one step per frame down to zero.
module vu_peak_hold #(
  parameter int HOLD_FRAMES = 30
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       update_i,
  input  logic [7:0] level_i,
  output logic [7:0] peak_o
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [7:0]        peak_q;
  logic [HOLD_W-1:0] hold_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      peak_q <= '0;
      hold_q <= '0;
    end else if (update_i) begin
      if (level_i >= peak_q) begin
        peak_q <= level_i;
        hold_q <= HOLD_W'(HOLD_FRAMES);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end else if (peak_q != 8'd0) begin
        peak_q <= peak_q - 8'd1;
      end
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/vu_frame_scheduler.sv
// Two-channel VU meter: latches level samples, commits them to the display
// only at frame edges, and renders the bars with a one-cycle pixel pipeline.
module vu_frame_scheduler
  import vu_pkg::*;
#(
  parameter int C_SIZE      = 9,
  parameter int BAR0_TOP    = 160,
  parameter int BAR1_TOP    = 288,
  parameter int BAR_H       = 32,
  parameter int HOLD_FRAMES = 30
) (
  input  logic            pixel_clock,
  input  logic            reset,
  input  logic            level_valid,
  input  logic            level_channel,
  input  logic [7:0]      level_value,
  output logic            level_ready,
  input  logic            v_sync,
  input  logic            disp_enable,
  input  logic [C_SIZE:0] row,
  input  logic [C_SIZE:0] column,
  output logic [11:0]     rgb
);

  localparam logic [C_SIZE:0] B0_LO = (C_SIZE+1)'(BAR0_TOP);
  localparam logic [C_SIZE:0] B0_HI = (C_SIZE+1)'(BAR0_TOP + BAR_H);
  localparam logic [C_SIZE:0] B1_LO = (C_SIZE+1)'(BAR1_TOP);
  localparam logic [C_SIZE:0] B1_HI = (C_SIZE+1)'(BAR1_TOP + BAR_H);

  state_e      state_q;
  logic        ready_q;
  logic        v_sync_q;
  logic        sync_armed_q;
  logic [7:0]  pending_q [2];
  logic [7:0]  disp_q    [2];
  logic [7:0]  peak_w    [2];
  logic [11:0] rgb_q;
  logic [11:0] rgb_d;
  logic        frame_edge;
  logic        decay_en;
  logic        in_bar0;
  logic        in_bar1;
  logic [15:0] pix_idx;

  // v_sync_q comes out of reset high, so the first post-reset cycle is
  // masked to keep a low v_sync at release from looking like an edge.
  assign frame_edge = sync_armed_q && v_sync_q && !v_sync;
  assign decay_en   = (state_q == ST_DECAY);

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      v_sync_q     <= 1'b1;
      sync_armed_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pending_q[i] <= '0;
        disp_q[i]    <= '0;
      end
    end else begin
      v_sync_q     <= v_sync;
      sync_armed_q <= 1'b1;
      if (level_valid && ready_q) pending_q[level_channel] <= level_value;
      case (state_q)
        ST_IDLE: begin
          if (frame_edge) begin
            state_q <= ST_COMMIT;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < 2; i++) disp_q[i] <= pending_q[i];
          state_q <= ST_DECAY;
          ready_q <= 1'b0;
        end
        ST_DECAY: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    vu_peak_hold #(
      .HOLD_FRAMES(HOLD_FRAMES)
    ) u_peak_hold (
      .clk_i   (pixel_clock),
      .srst_i  (reset),
      .update_i(decay_en),
      .level_i (disp_q[gi]),
      .peak_o  (peak_w[gi])
    );
  end

  assign pix_idx = 16'(column >> 1);
  assign in_bar0 = (row >= B0_LO) && (row < B0_HI);
  assign in_bar1 = (row >= B1_LO) && (row < B1_HI);

  always_comb begin
    rgb_d = COLOR_BLACK;
    if (disp_enable) begin
      if (in_bar0)      rgb_d = bar_colour(pix_idx, disp_q[0], peak_w[0]);
      else if (in_bar1) rgb_d = bar_colour(pix_idx, disp_q[1], peak_w[1]);
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) rgb_q <= COLOR_BLACK;
    else       rgb_q <= rgb_d;
  end

  assign level_ready = ready_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vu_frame_scheduler.sv
// Directed bench for vu_frame_scheduler: handshake, commit boundary, pixel
// colours, peak hold/decay and reset behaviour, observed through the ports.
module tb_vu_frame_scheduler;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        level_valid = 1'b0;
  logic        level_channel = 1'b0;
  logic [7:0]  level_value = 8'd0;
  logic        level_ready;
  logic        v_sync = 1'b1;
  logic        disp_enable = 1'b0;
  logic [9:0]  row = 10'd0;
  logic [9:0]  column = 10'd0;
  logic [11:0] rgb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pixel_clock = ~pixel_clock;

  vu_frame_scheduler dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .level_valid  (level_valid),
    .level_channel(level_channel),
    .level_value  (level_value),
    .level_ready  (level_ready),
    .v_sync       (v_sync),
    .disp_enable  (disp_enable),
    .row          (row),
    .column       (column),
    .rgb          (rgb)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pixel_clock);
      #1;
    end
  endtask

  task automatic send(input logic ch, input logic [7:0] val);
    level_valid   = 1'b1;
    level_channel = ch;
    level_value   = val;
    step(1);
    level_valid = 1'b0;
  endtask

  // One v_sync low pulse; returns once COMMIT and DECAY have completed.
  task automatic frame();
    v_sync = 1'b0;
    step(1);
    v_sync = 1'b1;
    step(2);
  endtask

  task automatic probe(input string tag, input int r, input int c, input logic de,
                       input logic [11:0] exp);
    row         = 10'(r);
    column      = 10'(c);
    disp_enable = de;
    step(1);
    check(tag, 32'(rgb), 32'(exp));
  endtask

  initial begin
    // Reset state and first cycle after release
    step(3);
    check("rst_rgb", 32'(rgb), 32'h000);
    check("rst_ready", 32'(level_ready), 32'd0);
    reset = 1'b0;
    step(1);
    check("ready_after_release", 32'(level_ready), 32'd1);
    probe("empty_bar0", 170, 0, 1'b1, 12'h222);

    // Latest pending sample wins
    send(1'b0, 8'd100);
    send(1'b0, 8'd120);
    frame();
    check("ready_idle", 32'(level_ready), 32'd1);
    probe("ch0_p119_green", 170, 238, 1'b1, 12'h0F0);
    probe("ch0_p120_peak", 170, 240, 1'b1, 12'hFFF);
    probe("ch0_p121_grey", 170, 242, 1'b1, 12'h222);

    // Sample accepted in the frame-edge cycle joins that commit
    level_valid   = 1'b1;
    level_channel = 1'b1;
    level_value   = 8'd50;
    v_sync        = 1'b0;
    check("ready_edge_cycle", 32'(level_ready), 32'd1);
    step(1);
    level_valid = 1'b0;
    v_sync      = 1'b1;
    check("ready_commit", 32'(level_ready), 32'd0);
    step(1);
    check("ready_decay", 32'(level_ready), 32'd0);
    step(1);
    check("ready_back", 32'(level_ready), 32'd1);
    probe("ch1_p49_green", 300, 98, 1'b1, 12'h0F0);
    probe("ch1_p50_peak", 300, 100, 1'b1, 12'hFFF);

    // Sample offered while busy must be dropped
    v_sync = 1'b0;
    step(1);
    v_sync        = 1'b1;
    level_valid   = 1'b1;
    level_channel = 1'b0;
    level_value   = 8'd77;
    step(1);
    level_valid = 1'b0;
    step(1);
    frame();
    probe("busy_sample_dropped", 170, 238, 1'b1, 12'h0F0);

    // Colour zones, priority and one-cycle latency
    send(1'b0, 8'd200);
    frame();
    probe("z_green", 170, 100, 1'b1, 12'h0F0);
    probe("z_yellow", 170, 360, 1'b1, 12'hFF0);
    probe("z_peak", 170, 400, 1'b1, 12'hFFF);
    probe("z_grey", 170, 420, 1'b1, 12'h222);
    probe("de_off", 170, 100, 1'b0, 12'h000);
    row = 10'd170; column = 10'd100; disp_enable = 1'b1;
    #2;
    check("latency_old_value", 32'(rgb), 32'h000);
    step(1);
    check("latency_new_value", 32'(rgb), 32'h0F0);
    probe("outside_bars", 200, 100, 1'b1, 12'h000);
    probe("bar0_last_row", 191, 100, 1'b1, 12'h0F0);
    probe("bar0_below", 192, 100, 1'b1, 12'h000);
    probe("bar0_above", 159, 100, 1'b1, 12'h000);
    send(1'b1, 8'd250);
    frame();
    probe("z_red", 300, 460, 1'b1, 12'hF00);
    probe("ch1_peak250", 300, 500, 1'b1, 12'hFFF);
    probe("bar1_first_row", 288, 460, 1'b1, 12'hF00);
    probe("bar1_last_row", 319, 460, 1'b1, 12'hF00);

    // Peak hold then decay to zero
    send(1'b0, 8'd0);
    for (int i = 0; i < 30; i++) frame();
    probe("hold_30_frames", 170, 400, 1'b1, 12'hFFF);
    frame();
    probe("decay_199", 170, 398, 1'b1, 12'hFFF);
    probe("decay_200_gone", 170, 400, 1'b1, 12'h222);
    frame();
    probe("decay_198", 170, 396, 1'b1, 12'hFFF);
    for (int i = 0; i < 197; i++) frame();
    probe("decay_1", 170, 2, 1'b1, 12'hFFF);
    frame();
    probe("decay_0_p0", 170, 0, 1'b1, 12'h222);
    probe("decay_0_p1", 170, 2, 1'b1, 12'h222);
    frame();
    probe("sat_0_p255", 170, 510, 1'b1, 12'h222);
    probe("sat_0_p0", 170, 0, 1'b1, 12'h222);

    // Reset during DECAY, then release with v_sync held low
    send(1'b0, 8'd90);
    send(1'b1, 8'd60);
    frame();
    probe("pre_reset_green", 170, 0, 1'b1, 12'h0F0);
    v_sync = 1'b0;
    step(1);
    v_sync = 1'b1;
    step(1);
    reset = 1'b1;
    step(1);
    check("rst_decay_rgb", 32'(rgb), 32'h000);
    check("rst_decay_ready", 32'(level_ready), 32'd0);
    v_sync = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);
    check("ready_one_after_release", 32'(level_ready), 32'd1);
    probe("cleared_disp0", 170, 0, 1'b1, 12'h222);
    probe("cleared_peak0", 170, 180, 1'b1, 12'h222);
    probe("cleared_disp1", 300, 0, 1'b1, 12'h222);
    step(3);
    check("no_edge_from_release", 32'(level_ready), 32'd1);
    v_sync = 1'b1;
    step(1);
    v_sync = 1'b0;
    step(1);
    check("true_edge_commit", 32'(level_ready), 32'd0);
    v_sync = 1'b1;
    step(2);
    check("true_edge_done", 32'(level_ready), 32'd1);
    probe("pending_cleared", 170, 0, 1'b1, 12'h222);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
